maxpool_param: RTL and testbench
================================

Name: maxpool_param

Overview:
- Parametrised 2x2/stride-2 pooling engine for the CNN feature-map path. Successor to the fixed 6x6 pooling stage.
- Accepts one flattened IN_H x IN_W frame per handshake and walks the true 2D windows, one window per cycle, through a 3-stage pipeline.
- Emits the (IN_H/2) x (IN_W/2) pooled frame with a valid/ready output handshake.
- Adds a runtime max/average mode, a signed/unsigned data option and full back-pressure.

Parameters:
- DATA_W, 8, pixel width in bits.
- IN_H, 6, input rows; must be even and >=2.
- IN_W, 6, input columns; must be even and >=2.
- SIGNED, 0, 1 = two's-complement compare/average, 0 = unsigned.
- Derived: OUT_H=IN_H/2, OUT_W=IN_W/2, N=OUT_H*OUT_W, CNT_W=clog2(N)+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- pool_valid_i  in  1  input frame valid.
- pool_ready_o  out  1  engine can accept a frame this cycle.
- pool_mode_i  in  1  0 = max, 1 = average; sampled on the accept cycle only.
- pool_input  in  IN_H*IN_W*DATA_W  frame; pixel (y,x) at bits [(y*IN_W+x)*DATA_W +: DATA_W].
- pool_valid_o  out  1  pooled frame valid.
- pool_ready_i  in  1  downstream accepts the pooled frame.
- pool_output  out  N*DATA_W  pooled frame; result (r,c) at bits [(r*OUT_W+c)*DATA_W +: DATA_W].
- pool_busy_o  out  1  high in RUN.

Behaviour:
- Reset (async, rst=1): state=IDLE, counters/pipeline regs/mode=0, pool_output=0, pool_valid_o=0, pool_busy_o=0. Any in-flight frame is discarded; no partial output is presented after reset.
- Accept: accept = pool_valid_i & pool_ready_o. pool_ready_o = (state==IDLE) | (state==DONE & pool_ready_i), combinational.
- On accept: frame and mode latched; idx=0; state->RUN.
- States and transitions:
  - IDLE: -> RUN on accept.
  - RUN: window idx fetched each cycle, idx 0..N-1. Enters DONE on the edge that writes slot N-1.
  - DONE: pool_valid_o=1 and pool_output frozen. On pool_ready_i: -> RUN if accept in the same cycle, else -> IDLE.
- Window idx, with r=idx/OUT_W and c=idx%OUT_W: pixels (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
- Pipeline, with edges counted from the accept edge (edge 0):
  - Edge k+1, k=0..N-1: stage 1 registers the 4 pixels of window k.
  - Edge k+2: stage 2 registers the pair reductions (p0,p1) and (p2,p3).
  - Edge k+3: stage 3 writes slot k. (Window k is fetched on edge k+1, so its slot is written 2 edges later.)
- Latency: pool_valid_o rises on edge N+2, the same edge that writes slot N-1. For 6x6, N=9, so 11 cycles.
- Stage enables: pipeline stages advance only while a window is in flight. Slots outside the current frame are never written; all N slots are rewritten each frame.
- Max mode: compare per SIGNED. On a tie either operand is returned; the values are equal, so the result is deterministic.
- Average mode:
  - Stage 2 sums pairs to DATA_W+1 bits (sign- or zero-extended); stage 3 sums to DATA_W+2 bits.
  - Result = sum >>> 2 (arithmetic if SIGNED), i.e. floor division, truncated to DATA_W. No overflow is possible.
- Back-pressure: while in DONE with pool_ready_i=0, pool_output and pool_valid_o hold indefinitely. pool_input changes are ignored.
- Back-to-back: a new frame accepted in the DONE-handshake cycle drops pool_valid_o on that edge. The old output stays visible until slot 0 is overwritten at edge 3; no bubble beyond the pipeline fill.
- pool_valid_i while busy: ignored, and the frame is not queued. The source must hold it until pool_ready_o.
- Mode change mid-frame: no effect; the latched mode applies to the whole frame.

Decomposition:
- Shared package/include cnn_pool_pkg holds:
  - mode constants POOL_MAX=1'b0, POOL_AVG=1'b1;
  - state encoding IDLE/RUN/DONE (2-bit);
  - helper function for the pixel bit offset (y,x,IN_W,DATA_W).
- Sub-module pool_reduce4 (params DATA_W, SIGNED): 4 inputs, mode, in_valid. Stages 2–3 of the pipeline, 2-cycle latency, out_valid.
- Top level owns the FSM, frame/mode latch, window address generation, stage 1 and the output slot write.

Test Plan:
1. 6x6 unsigned, max mode, pixel(y,x)=y*6+x -> pool_output slots 0..8 = 7,9,11,19,21,23,31,33,35; pool_valid_o rises exactly 11 cycles after accept.
2. Same frame, avg mode -> slots = 3,5,7,15,17,19,27,29,31.
3. SIGNED=1, window pixels 0x80,0xFF,0xFE,0xFD, rest 0 -> max slot0=0xFF (-1); avg slot0=0xDE (-134>>>2 = -34).
4. Back-pressure: hold pool_ready_i=0 for 20 cycles after valid -> output bits and pool_valid_o stable, pool_ready_o=0. Toggle pool_input/pool_valid_i meanwhile -> no effect.
5. Back-to-back: pool_ready_i=1 with pool_valid_i=1 in DONE -> second frame accepted that edge; its result valid 11 cycles later, correct values, no dropped frame.
6. Reset mid-RUN (rst pulse at cycle 5 of frame) -> all outputs 0 immediately (async). A next frame accepted after release produces correct results with no residue from the aborted frame.

Source files
------------

// File: rtl/cnn_pool_pkg.sv
// Shared definitions for the CNN pooling engine:
// mode codes, FSM state encoding and pixel addressing.
package cnn_pool_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_t;

    function automatic int pix_off(int y, int x, int in_w, int data_w);
        return (y * in_w + x) * data_w;
    endfunction

endpackage

// File: rtl/maxpool_param_if.sv
// Frame-in / pooled-frame-out handshake bundle for maxpool_param.
// slave = engine side, master = source/sink side.
interface maxpool_param_if #(
    parameter int DATA_W = 8,
    parameter int IN_H   = 6,
    parameter int IN_W   = 6
);
    localparam int N = (IN_H / 2) * (IN_W / 2);

    logic                         pool_valid_i;
    logic                         pool_ready_o;
    logic                         pool_mode_i;
    logic [IN_H*IN_W*DATA_W-1:0]  pool_input;
    logic                         pool_valid_o;
    logic                         pool_ready_i;
    logic [N*DATA_W-1:0]          pool_output;
    logic                         pool_busy_o;

    modport slave (
        input  pool_valid_i, pool_mode_i, pool_input, pool_ready_i,
        output pool_ready_o, pool_valid_o, pool_output, pool_busy_o
    );

    modport master (
        output pool_valid_i, pool_mode_i, pool_input, pool_ready_i,
        input  pool_ready_o, pool_valid_o, pool_output, pool_busy_o
    );

endinterface

// File: rtl/pool_reduce4.sv
// Pipeline stages 2-3: pair reduction registered, final
// reduction combinational so the top writes the slot next edge.
module pool_reduce4
    import cnn_pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SIGNED = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   mode,
    input  logic [3:0][DATA_W-1:0] px,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data
);

    localparam int EW = DATA_W + 1;
    localparam int SW = DATA_W + 2;

    logic          s2_v_q, s2_v_d;
    logic          s2_mode_q, s2_mode_d;
    logic [EW-1:0] s2_x_q, s2_x_d;
    logic [EW-1:0] s2_y_q, s2_y_d;
    logic [EW-1:0] e0, e1, e2, e3, mx;
    logic [SW-1:0] sum;

    function automatic logic [EW-1:0] ext1(logic [DATA_W-1:0] v);
        return (SIGNED != 0) ? {v[DATA_W-1], v} : {1'b0, v};
    endfunction

    function automatic logic [SW-1:0] ext2(logic [EW-1:0] v);
        return (SIGNED != 0) ? {v[EW-1], v} : {1'b0, v};
    endfunction

    // Sign-extension preserves ordering, so one compare serves both stages.
    function automatic logic gt(logic [EW-1:0] a, logic [EW-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // Stage 2: reduce (p0,p1) and (p2,p3); hold while no window arrives.
    always_comb begin
        s2_v_d    = in_valid;
        s2_mode_d = s2_mode_q;
        s2_x_d    = s2_x_q;
        s2_y_d    = s2_y_q;
        e0        = ext1(px[0]);
        e1        = ext1(px[1]);
        e2        = ext1(px[2]);
        e3        = ext1(px[3]);
        if (in_valid) begin
            s2_mode_d = mode;
            if (mode == POOL_AVG) begin
                s2_x_d = e0 + e1;
                s2_y_d = e2 + e3;
            end else begin
                s2_x_d = gt(e0, e1) ? e0 : e1;
                s2_y_d = gt(e2, e3) ? e2 : e3;
            end
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_q    <= 1'b0;
            s2_mode_q <= POOL_MAX;
            s2_x_q    <= '0;
            s2_y_q    <= '0;
        end else begin
            s2_v_q    <= s2_v_d;
            s2_mode_q <= s2_mode_d;
            s2_x_q    <= s2_x_d;
            s2_y_q    <= s2_y_d;
        end
    end

    // Stage 3: final max, or 4-way sum floored by 4 (low DATA_W bits).
    always_comb begin
        sum       = ext2(s2_x_q) + ext2(s2_y_q);
        mx        = gt(s2_x_q, s2_y_q) ? s2_x_q : s2_y_q;
        out_valid = s2_v_q;
        if (s2_mode_q == POOL_AVG) out_data = DATA_W'(sum >> 2);
        else                       out_data = DATA_W'(mx);
    end

endmodule

// File: rtl/maxpool_param.sv
// 2x2/stride-2 pooling engine: frame latch, FSM, window walk,
// stage 1 fetch and output slot write around pool_reduce4.
module maxpool_param
    import cnn_pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IN_H   = 6,
    parameter int IN_W   = 6,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst,
    maxpool_param_if.slave  bus
);

    localparam int OUT_W = IN_W / 2;
    localparam int N     = (IN_H / 2) * OUT_W;
    localparam int CNT_W = $clog2(N) + 1;
    localparam int FW    = IN_H * IN_W * DATA_W;
    localparam int OW    = N * DATA_W;

    localparam logic [CNT_W-1:0] N_C      = CNT_W'(N);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(OUT_W - 1);
    localparam logic [OW-1:0]    SLOT_M   = OW'({DATA_W{1'b1}});

    pool_state_t             state_q, state_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        row_q, row_d;
    logic [CNT_W-1:0]        col_q, col_d;
    logic [CNT_W-1:0]        wr_q, wr_d;
    logic                    mode_q, mode_d;
    logic [FW-1:0]           frame_q, frame_d;
    logic                    s1_v_q, s1_v_d;
    logic [3:0][DATA_W-1:0]  s1_px_q, s1_px_d;
    logic [OW-1:0]           out_q, out_d;
    logic                    ready, accept, fetch;
    logic                    r_valid;
    logic [DATA_W-1:0]       r_data;
    int                      y0, x0, sh;

    pool_reduce4 #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_reduce (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_v_q),
        .mode      (mode_q),
        .px        (s1_px_q),
        .out_valid (r_valid),
        .out_data  (r_data)
    );

    // FSM next state, frame latch, window walk and slot write.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        wr_d    = wr_q;
        mode_d  = mode_q;
        frame_d = frame_q;
        s1_px_d = s1_px_q;
        out_d   = out_q;
        ready   = (state_q == IDLE) ||
                  (state_q == DONE && bus.pool_ready_i);
        accept  = bus.pool_valid_i && ready;
        fetch   = (state_q == RUN) && (idx_q < N_C);
        s1_v_d  = fetch;
        y0      = 2 * int'(row_q);
        x0      = 2 * int'(col_q);
        sh      = int'(wr_q) * DATA_W;

        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (r_valid && wr_q == LAST_C) state_d = DONE;
            DONE:    if (bus.pool_ready_i) state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            frame_d = bus.pool_input;
            mode_d  = bus.pool_mode_i;
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            wr_d    = '0;
        end

        if (fetch) begin
            s1_px_d[0] = DATA_W'(frame_q >> pix_off(y0,     x0,     IN_W, DATA_W));
            s1_px_d[1] = DATA_W'(frame_q >> pix_off(y0,     x0 + 1, IN_W, DATA_W));
            s1_px_d[2] = DATA_W'(frame_q >> pix_off(y0 + 1, x0,     IN_W, DATA_W));
            s1_px_d[3] = DATA_W'(frame_q >> pix_off(y0 + 1, x0 + 1, IN_W, DATA_W));
            idx_d = idx_q + 1'b1;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (r_valid) begin
            out_d = (out_q & ~(SLOT_M << sh)) | (OW'(r_data) << sh);
            wr_d  = wr_q + 1'b1;
        end
    end

    // State, counters, latched frame, stage 1 and output slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wr_q    <= '0;
            mode_q  <= POOL_MAX;
            frame_q <= '0;
            s1_v_q  <= 1'b0;
            s1_px_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wr_q    <= wr_d;
            mode_q  <= mode_d;
            frame_q <= frame_d;
            s1_v_q  <= s1_v_d;
            s1_px_q <= s1_px_d;
            out_q   <= out_d;
        end
    end

    assign bus.pool_ready_o = ready;
    assign bus.pool_valid_o = (state_q == DONE);
    assign bus.pool_busy_o  = (state_q == RUN);
    assign bus.pool_output  = out_q;

endmodule

// File: tb/tb_maxpool_param.sv
// Scoreboard bench for maxpool_param: unsigned and signed
// instances, directed frames with hand-computed results.
module tb_maxpool_param;

    localparam int DW = 8;
    localparam int H  = 6;
    localparam int W  = 6;
    localparam int N  = 9;
    localparam int FW = H * W * DW;
    localparam int OW = N * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    maxpool_param_if #(.DATA_W(DW), .IN_H(H), .IN_W(W)) b0 ();
    maxpool_param_if #(.DATA_W(DW), .IN_H(H), .IN_W(W)) b1 ();

    maxpool_param #(.DATA_W(DW), .IN_H(H), .IN_W(W), .SIGNED(0)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    maxpool_param #(.DATA_W(DW), .IN_H(H), .IN_W(W), .SIGNED(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    logic [OW-1:0] q0[$];
    logic [OW-1:0] q1[$];
    int            acc0 = 0, acc1 = 0;
    logic          pv0 = 1'b0, pv1 = 1'b0;

    int emax[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    int eavg[9] = '{3, 5, 7, 15, 17, 19, 27, 29, 31};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_frame(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        for (int i = 0; i < N; i++)
            check($sformatf("%s slot%0d", tag, i), 64'(act[i*DW +: DW]), 64'(exp[i*DW +: DW]));
    endtask

    function automatic logic [OW-1:0] pack9(input int v[9], input int off);
        logic [OW-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(v[i] + off);
        return r;
    endfunction

    function automatic logic [FW-1:0] ramp(input int off);
        logic [FW-1:0] r = '0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                r[(y*W+x)*DW +: DW] = DW'(y * W + x + off);
        return r;
    endfunction

    // Monitor for the unsigned instance.
    always @(negedge clk) begin
        if (rst) begin
            pv0 = 1'b0;
        end else begin
            if (b0.pool_valid_o && !pv0) check("lat0", 64'(cyc - acc0), 64'd11);
            pv0 = b0.pool_valid_o;
            if (b0.pool_valid_o && b0.pool_ready_i) begin
                if (q0.size() == 0) check("spurious0", 64'd1, 64'd0);
                else cmp_frame("u0", b0.pool_output, q0.pop_front());
            end
            if (b0.pool_valid_i && b0.pool_ready_o) acc0 = cyc + 1;
        end
    end

    // Monitor for the signed instance.
    always @(negedge clk) begin
        if (rst) begin
            pv1 = 1'b0;
        end else begin
            if (b1.pool_valid_o && !pv1) check("lat1", 64'(cyc - acc1), 64'd11);
            pv1 = b1.pool_valid_o;
            if (b1.pool_valid_o && b1.pool_ready_i) begin
                if (q1.size() == 0) check("spurious1", 64'd1, 64'd0);
                else cmp_frame("u1", b1.pool_output, q1.pop_front());
            end
            if (b1.pool_valid_i && b1.pool_ready_o) acc1 = cyc + 1;
        end
    end

    task automatic send0(input logic [FW-1:0] f, input logic m);
        int t = 0;
        b0.pool_input   = f;
        b0.pool_mode_i  = m;
        b0.pool_valid_i = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!b0.pool_ready_o && t < 100);
        if (!b0.pool_ready_o) check("accept_timeout0", 64'd0, 64'd1);
        @(posedge clk);
        #1 b0.pool_valid_i = 1'b0;
    endtask

    task automatic send1(input logic [FW-1:0] f, input logic m);
        int t = 0;
        b1.pool_input   = f;
        b1.pool_mode_i  = m;
        b1.pool_valid_i = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!b1.pool_ready_o && t < 100);
        if (!b1.pool_ready_o) check("accept_timeout1", 64'd0, 64'd1);
        @(posedge clk);
        #1 b1.pool_valid_i = 1'b0;
    endtask

    task automatic wait_valid0();
        int t = 0;
        while (!b0.pool_valid_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!b0.pool_valid_o) check("valid_timeout0", 64'd0, 64'd1);
    endtask

    task automatic wait_valid1();
        int t = 0;
        while (!b1.pool_valid_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!b1.pool_valid_o) check("valid_timeout1", 64'd0, 64'd1);
    endtask

    initial begin
        logic [FW-1:0] sf;
        logic [OW-1:0] snap;
        logic [OW-1:0] e;
        int bad;

        b0.pool_valid_i = 1'b0;
        b0.pool_mode_i  = 1'b0;
        b0.pool_input   = '0;
        b0.pool_ready_i = 1'b1;
        b1.pool_valid_i = 1'b0;
        b1.pool_mode_i  = 1'b0;
        b1.pool_input   = '0;
        b1.pool_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst valid_o", 64'(b0.pool_valid_o), 64'd0);
        check("rst ready_o", 64'(b0.pool_ready_o), 64'd1);
        check("rst busy_o", 64'(b0.pool_busy_o), 64'd0);
        check("rst output", 64'(b0.pool_output), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Max mode on the ramp frame; busy right after accept.
        q0.push_back(pack9(emax, 0));
        send0(ramp(0), 1'b0);
        check("busy in run", 64'(b0.pool_busy_o), 64'd1);
        wait_valid0();
        @(posedge clk);
        #1;

        // Average mode on the same frame.
        q0.push_back(pack9(eavg, 0));
        send0(ramp(0), 1'b1);
        wait_valid0();
        @(posedge clk);
        #1;

        // Back-pressure: output must hold while input side is toggled.
        b0.pool_ready_i = 1'b0;
        q0.push_back(pack9(emax, 50));
        send0(ramp(50), 1'b0);
        wait_valid0();
        snap = b0.pool_output;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            b0.pool_input   = {9{$urandom()}};
            b0.pool_valid_i = ~b0.pool_valid_i;
            b0.pool_mode_i  = ~b0.pool_mode_i;
            @(negedge clk);
            if (b0.pool_output !== snap || !b0.pool_valid_o || b0.pool_ready_o) bad++;
        end
        check("backpressure hold", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        b0.pool_valid_i = 1'b0;
        b0.pool_ready_i = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("idle after release", 64'(b0.pool_valid_o), 64'd0);

        // Back-to-back: next frame accepted in the DONE handshake cycle.
        b0.pool_ready_i = 1'b0;
        q0.push_back(pack9(emax, 0));
        send0(ramp(0), 1'b0);
        wait_valid0();
        @(posedge clk);
        #1;
        b0.pool_ready_i = 1'b1;
        q0.push_back(pack9(eavg, 100));
        send0(ramp(100), 1'b1);
        check("b2b valid drop", 64'(b0.pool_valid_o), 64'd0);
        wait_valid0();
        @(posedge clk);
        #1;

        // Reset in the middle of a frame; aborted frame never reported.
        send0(ramp(0), 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst valid_o", 64'(b0.pool_valid_o), 64'd0);
        check("midrst busy_o", 64'(b0.pool_busy_o), 64'd0);
        check("midrst output", 64'(b0.pool_output), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        q0.push_back(pack9(eavg, 7));
        send0(ramp(7), 1'b1);
        wait_valid0();
        @(posedge clk);
        #1;

        // Signed instance: window 0x80,0xFF,0xFE,0xFD, rest zero.
        sf = '0;
        sf[7:0]   = 8'h80;
        sf[15:8]  = 8'hFF;
        sf[55:48] = 8'hFE;
        sf[63:56] = 8'hFD;
        e = '0;
        e[7:0] = 8'hFF;
        q1.push_back(e);
        send1(sf, 1'b0);
        wait_valid1();
        @(posedge clk);
        #1;
        e[7:0] = 8'hDE;
        q1.push_back(e);
        send1(sf, 1'b1);
        wait_valid1();
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;

        check("q0 drained", 64'(q0.size()), 64'd0);
        check("q1 drained", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
